// File: rtl/trig_pkg.sv
// Shared definitions for the trigger event stamper.
//   state_e  : FSM state encoding (IDLE=0, ARMED=1, WAIT_T1=2, DONE=3)
//   EVT_*    : two-bit event codes carried in the top bits of every event word
//   WAIT_W   : width of the T1 wait counter, which matches the timeout_cycles port
package trig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_WAIT_T1 = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic [1:0] EVT_T0  = 2'b01;
   localparam logic [1:0] EVT_T1  = 2'b10;
   localparam logic [1:0] EVT_TMO = 2'b11;

   localparam int WAIT_W = 24;

endpackage

// File: rtl/trig_evt_fifo.sv
// Event FIFO with a valid/ready read port.
// Parameters: WIDTH (word width), DEPTH (power of two, >= 2).
// Ports:
//   clk_i, rst_n_i        : clock, async active-low reset
//   push_i, push_data_i   : write request and word
//   valid_o, ready_i      : read handshake; a pop happens when both are high
//   data_o                : head word, held stable while valid_o && !ready_i
//   drop_o                : a push was refused because the FIFO was full with no pop
module trig_evt_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   // One extra MSB on each pointer separates full from empty.
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             full;
   logic             pop;
   logic             push_ok;

   assign valid_o = (wr_ptr_q != rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = valid_o && ready_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push_i && (!full || pop);
   assign drop_o  = push_i && full && !pop;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/trig_event_stamp.sv
// Trigger event stamper: timestamps a trigger0 edge, then either a trigger1
// edge or a wait timeout, and queues the records for a valid/ready consumer.
// Build option: define TRIG_STAMP_DELTA_EN to report the T1 payload as
// (ts1 - ts0) instead of the absolute timestamp; otherwise no ts0 register.
// Parameters: TS_WIDTH (timestamp width), FIFO_DEPTH (power of two, >= 2).
// Ports:
//   adc_clk, adc_rstn         : clock, async active-low reset
//   arm, abort                : capture start request / return to IDLE
//   trigger0, trigger1        : trigger levels, rising edges are events
//   timeout_cycles            : T1 wait limit, 0 = no timeout
//   m_valid, m_ready, m_data  : event stream, m_data = {code[1:0], payload}
//   state_o                   : current FSM state
//   overflow                  : sticky, an event was dropped
//
// state    | meaning
// IDLE     | waiting for arm
// ARMED    | waiting for a trigger0 rising edge
// WAIT_T1  | T0 recorded, waiting for trigger1 edge or timeout
// DONE     | capture finished, arm starts another
module trig_event_stamp
   import trig_pkg::*;
#(
   parameter int TS_WIDTH   = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                adc_clk,
   input  logic                adc_rstn,
   input  logic                arm,
   input  logic                abort,
   input  logic                trigger0,
   input  logic                trigger1,
   input  logic [WAIT_W-1:0]   timeout_cycles,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [TS_WIDTH+1:0] m_data,
   output logic [1:0]          state_o,
   output logic                overflow
);

   state_e              state_q;
   logic [TS_WIDTH-1:0] ts_q;
   logic                trig0_q;
   logic                trig1_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                ovf_q;
`ifdef TRIG_STAMP_DELTA_EN
   logic [TS_WIDTH-1:0] ts0_q;
`endif

   logic                edge0;
   logic                edge1;
   logic [WAIT_W-1:0]   wait_inc;
   logic                tmo_hit;
   logic [TS_WIDTH-1:0] t1_payload;
   logic                push;
   logic [TS_WIDTH+1:0] push_word;
   logic                drop;

   assign edge0    = trigger0 && !trig0_q;
   assign edge1    = trigger1 && !trig1_q;
   // wait_q counts completed WAIT_T1 cycles, so this cycle is number wait_q+1.
   assign wait_inc = wait_q + WAIT_W'(1);
   assign tmo_hit  = (timeout_cycles != '0) && (wait_inc == timeout_cycles);

`ifdef TRIG_STAMP_DELTA_EN
   assign t1_payload = ts_q - ts0_q;
`else
   assign t1_payload = ts_q;
`endif

   always_comb begin
      push      = 1'b0;
      push_word = '0;
      if (!abort) begin
         case (state_q)
            ST_ARMED: begin
               if (edge0) begin
                  push      = 1'b1;
                  push_word = {EVT_T0, ts_q};
               end
            end
            ST_WAIT_T1: begin
               // trigger1 wins over a timeout landing in the same cycle.
               if (edge1) begin
                  push      = 1'b1;
                  push_word = {EVT_T1, t1_payload};
               end else if (tmo_hit) begin
                  push      = 1'b1;
                  push_word = {EVT_TMO, TS_WIDTH'(wait_inc)};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge adc_clk or negedge adc_rstn) begin
      if (!adc_rstn) begin
         state_q <= ST_IDLE;
         ts_q    <= '0;
         trig0_q <= 1'b0;
         trig1_q <= 1'b0;
         wait_q  <= '0;
         ovf_q   <= 1'b0;
`ifdef TRIG_STAMP_DELTA_EN
         ts0_q   <= '0;
`endif
      end else begin
         ts_q    <= ts_q + TS_WIDTH'(1);
         trig0_q <= trigger0;
         trig1_q <= trigger1;
         if (drop) begin
            ovf_q <= 1'b1;
         end
         if (abort) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE, ST_DONE: begin
                  if (arm) begin
                     state_q <= ST_ARMED;
                     ovf_q   <= 1'b0;
                  end
               end
               ST_ARMED: begin
                  if (edge0) begin
                     state_q <= ST_WAIT_T1;
                     wait_q  <= '0;
`ifdef TRIG_STAMP_DELTA_EN
                     ts0_q   <= ts_q;
`endif
                  end
               end
               ST_WAIT_T1: begin
                  wait_q <= wait_inc;
                  if (edge1 || tmo_hit) begin
                     state_q <= ST_DONE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign state_o  = state_q;
   assign overflow = ovf_q;

   trig_evt_fifo #(
      .WIDTH (TS_WIDTH + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (adc_clk),
      .rst_n_i     (adc_rstn),
      .push_i      (push),
      .push_data_i (push_word),
      .valid_o     (m_valid),
      .ready_i     (m_ready),
      .data_o      (m_data),
      .drop_o      (drop)
   );

endmodule

// File: tb/tb_trig_event_stamp.sv
// Bench for trig_event_stamp (TS_WIDTH=8, FIFO_DEPTH=4). A cycle-level
// reference model predicts event words into a queue; a separate monitor
// pops and compares on every m_valid && m_ready handshake.
module tb_trig_event_stamp;

   localparam int TW    = 8;
   localparam int DEPTH = 4;
   localparam int DW    = TW + 2;

   logic          adc_clk  = 1'b0;
   logic          adc_rstn = 1'b0;
   logic          arm      = 1'b0;
   logic          abort    = 1'b0;
   logic          trigger0 = 1'b0;
   logic          trigger1 = 1'b0;
   logic          m_ready  = 1'b0;
   logic [23:0]   timeout_cycles = '0;
   logic          m_valid;
   logic          overflow;
   logic [DW-1:0] m_data;
   logic [1:0]    state_o;

   always #5 adc_clk = ~adc_clk;

   trig_event_stamp #(.TS_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
      .adc_clk        (adc_clk),
      .adc_rstn       (adc_rstn),
      .arm            (arm),
      .abort          (abort),
      .trigger0       (trigger0),
      .trigger1       (trigger1),
      .timeout_cycles (timeout_cycles),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .state_o        (state_o),
      .overflow       (overflow)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] log_data [$];
   time           log_time [$];

   // reference model: cycle index since reset, phase 0..3, occupancy
   int m_cyc, m_t0_cyc, m_phase, m_cnt;
   bit m_ovf, m_p0, m_p1;

   task automatic check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs (seen by the next posedge) and advances the model.
   task automatic step(bit a, bit ab, bit t0, bit t1, bit rdy);
      bit            e0, e1, pop, push;
      logic [DW-1:0] w;
      logic [TW-1:0] ts, eb;
      int            el;
      @(negedge adc_clk); #1;
      check("state", state_o, m_phase);
      check("overflow", overflow, m_ovf);
      check("m_valid", m_valid, m_cnt > 0);
      adc_rstn = 1'b1;
      arm = a; abort = ab; trigger0 = t0; trigger1 = t1; m_ready = rdy;
      e0   = t0 && !m_p0;
      e1   = t1 && !m_p1;
      pop  = (m_cnt > 0) && rdy;
      push = 1'b0;
      w    = '0;
      ts   = m_cyc[TW-1:0];
      if (ab) m_phase = 0;
      else begin
         case (m_phase)
            0, 3: if (a) begin m_phase = 1; m_ovf = 1'b0; end
            1: if (e0) begin push = 1'b1; w = {2'b01, ts}; m_t0_cyc = m_cyc; m_phase = 2; end
            2: begin
               el = m_cyc - m_t0_cyc;
               eb = el[TW-1:0];
               if (e1) begin
                  push = 1'b1;
`ifdef TRIG_STAMP_DELTA_EN
                  w = {2'b10, eb};
`else
                  w = {2'b10, ts};
`endif
                  m_phase = 3;
               end else if (timeout_cycles != 0 && el == int'(timeout_cycles)) begin
                  push = 1'b1; w = {2'b11, eb}; m_phase = 3;
               end
            end
            default: ;
         endcase
      end
      if (push) begin
         if (m_cnt < DEPTH || pop) begin exp_q.push_back(w); m_cnt++; end
         else m_ovf = 1'b1;
      end
      if (pop) m_cnt--;
      m_p0 = t0; m_p1 = t1;
      m_cyc++;
   endtask

   task automatic do_reset();
      @(negedge adc_clk); #1;
      adc_rstn = 1'b0;
      arm = 0; abort = 0; trigger0 = 0; trigger1 = 0; m_ready = 0;
      exp_q.delete(); log_data.delete(); log_time.delete();
      m_cyc = 0; m_phase = 0; m_cnt = 0; m_ovf = 0; m_p0 = 0; m_p1 = 0;
      repeat (2) @(negedge adc_clk);
      #1;
      check("rst_state", state_o, 0);
      check("rst_valid", m_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_data", m_data, 0);
   endtask

   // monitor
   bit            hold_prev = 1'b0;
   logic [DW-1:0] prev_data;
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge adc_clk); #3;
         if (adc_rstn && m_valid) begin
            if (hold_prev) check("m_data_hold", m_data, prev_data);
            if (m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL pop_unexpected actual=%0h expected=none t=%0t", m_data, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("m_data", m_data, e);
               end
               log_data.push_back(m_data);
               log_time.push_back($time);
            end
            hold_prev = !m_ready;
            prev_data = m_data;
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r0, r1, a, ab, rdy;
      // basic T0 then T1
      do_reset();
      for (int k = 0; k < 100; k++) step(k == 10, 0, k >= 20, k >= 70, 1);
      check("a_count", log_data.size(), 2);
      if (log_data.size() >= 2) begin
         check("a_t0", log_data[0], {2'b01, 8'd20});
`ifdef TRIG_STAMP_DELTA_EN
         check("a_t1", log_data[1], {2'b10, 8'd50});
`else
         check("a_t1", log_data[1], {2'b10, 8'd70});
`endif
      end
      check("a_state", state_o, 3);

      // timeout
      do_reset();
      timeout_cycles = 24'd100;
      for (int k = 0; k < 130; k++) step(k == 2, 0, k >= 5, 0, 1);
      check("b_count", log_data.size(), 2);
      if (log_data.size() >= 2) begin
         check("b_tmo", log_data[1], {2'b11, 8'd100});
         check("b_gap", log_time[1] - log_time[0], 1000);
      end
      check("b_state", state_o, 3);
      timeout_cycles = '0;

      // overflow with consumer stalled
      do_reset();
      for (int c = 0; c < 5; c++) begin
         step(1, 0, 0, 0, 0);
         step(0, 0, 1, 0, 0);
         step(0, 0, 1, 1, 0);
         step(0, 0, 0, 0, 0);
      end
      check("c_ovf", overflow, 1);
      repeat (8) step(0, 0, 0, 0, 1);
      check("c_count", log_data.size(), 4);
      if (log_data.size() >= 4) begin
         check("c_first", log_data[0], {2'b01, 8'd1});
`ifdef TRIG_STAMP_DELTA_EN
         check("c_last", log_data[3], {2'b10, 8'd1});
`else
         check("c_last", log_data[3], {2'b10, 8'd6});
`endif
      end
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      check("c_ovf_clr", overflow, 0);

      // simultaneous edges in ARMED
      do_reset();
      for (int k = 0; k < 20; k++) step(k == 1, 0, k >= 3, (k == 3) || (k >= 8), 1);
      check("d_count", log_data.size(), 2);
      if (log_data.size() >= 2) begin
         check("d_t0", log_data[0], {2'b01, 8'd3});
`ifdef TRIG_STAMP_DELTA_EN
         check("d_t1", log_data[1], {2'b10, 8'd5});
`else
         check("d_t1", log_data[1], {2'b10, 8'd8});
`endif
      end

      // abort in WAIT_T1
      do_reset();
      for (int k = 0; k < 16; k++) step(k == 1, k == 6, k >= 3, k >= 8, 1);
      check("e_count", log_data.size(), 1);
      check("e_state", state_o, 0);

      // reset mid-capture with an event queued
      do_reset();
      for (int k = 0; k < 6; k++) step(k == 1, 0, k >= 3, 0, 0);
      do_reset();
      for (int k = 0; k < 12; k++) step(k == 2, 0, k >= 4, 0, 1);
      check("f_count", log_data.size(), 1);
      if (log_data.size() >= 1) check("f_ts_restart", log_data[0], {2'b01, 8'd4});

      // timestamp wrap at TS_WIDTH=8
      do_reset();
      for (int k = 0; k < 270; k++) step(k == 240, 0, k >= 250, k >= 260, 1);
      check("g_count", log_data.size(), 2);
      if (log_data.size() >= 2) begin
`ifdef TRIG_STAMP_DELTA_EN
         check("g_t1", log_data[1], {2'b10, 8'd10});
`else
         check("g_t1", log_data[1], {2'b10, 8'd4});
`endif
      end

      // randomized traffic
      do_reset();
      r0 = 0; r1 = 0;
      for (int k = 0; k < 1500; k++) begin
         if (m_phase != 2 && $urandom_range(0, 15) == 0)
            timeout_cycles = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 30));
         if ($urandom_range(0, 3) == 0) r0 = !r0;
         if ($urandom_range(0, 3) == 0) r1 = !r1;
         a   = ($urandom_range(0, 7) == 0);
         ab  = ($urandom_range(0, 39) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            r0 = 0; r1 = 0;
         end
         step(a, ab, r0, r1, rdy);
      end
      repeat (10) step(0, 0, 0, 0, 1);
      check("drain_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
